// File: rtl/pkg_graybin.sv
// Shared constants and types for the gray/binary FIFO and its read-side drain stage.
package pkg_graybin;

  // FIFO depth; the data word width follows from it.
  localparam int DEPTH = 256;
  localparam int DW = $clog2(DEPTH);

  // FIFO_top returns read data one cycle after the accepted read.
  localparam int FIFO_RD_LATENCY = 1;

  // Entries in the drain stage's skid buffer.
  localparam int SKID_DEPTH = 2;

  // One FIFO data word.
  typedef logic [DW-1:0] word_t;

  // Buffer occupancy after one edge of pushes and pops.
  function automatic logic [1:0] level_next(input logic [1:0] level,
                                            input logic push,
                                            input logic pop);
    return level + {1'b0, push} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry in-order buffer. Entry 0 is always the head; a pop shifts
// entry 1 down, and a push lands in the first free slot after that shift.
module fifo_skid2
  import pkg_graybin::*;
#(
  parameter int DW = pkg_graybin::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [1:0]    cnt
);

  logic [DW-1:0] mem_reg [SKID_DEPTH];
  logic [1:0]    cnt_reg;
  logic [1:0]    slot;

  // Slot a pushed word goes to, after any pop on the same edge.
  assign slot = cnt_reg - {1'b0, pop};

  // Occupancy and storage update; the push write overrides the shift into entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
    end else begin
      cnt_reg <= level_next(cnt_reg, push, pop);
      if (pop) begin
        mem_reg[0] <= mem_reg[1];
      end
      if (push) begin
        if (slot == 2'd0) begin
          mem_reg[0] <= din;
        end else begin
          mem_reg[1] <= din;
        end
      end
    end
  end

  assign dout = mem_reg[0];
  assign cnt  = cnt_reg;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pulls words out of FIFO_top, hides its read latency
// in a two-entry skid buffer and presents a framed valid/ready stream.
module fifo_rd_stream
  import pkg_graybin::*;
#(
  parameter int DW      = pkg_graybin::DW,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             i_rclk,
  input  logic             i_rrst_n,
  input  logic [DW-1:0]    i_fifo_data,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rden,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [DW-1:0]    o_data,
  output logic             o_last,
  output logic [CNT_W-1:0] o_pkt_cnt
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic             inflight_reg;
  logic [CNT_W-1:0] beat_reg;
  logic [CNT_W-1:0] pkt_reg;
  logic [1:0]       cnt;
  logic [1:0]       level;
  logic             pop;
  logic             is_last;

  assign pop = o_valid & i_ready;

  // Words held or already on their way once this edge's pop is taken out.
  // cnt + inflight never exceeds 2, so two bits are enough.
  assign level = level_next(cnt, inflight_reg, pop);

  // Only issue a read when the word it returns is guaranteed a free slot.
  assign o_fifo_rden = i_rrst_n & ~i_fifo_empty & (level < 2'd2);

  // Remember that FIFO_top returns a word next cycle; cleared by reset so a
  // word arriving right after release is dropped.
  always_ff @(posedge i_rclk) begin
    if (!i_rrst_n) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= o_fifo_rden & ~i_fifo_empty;
    end
  end

  fifo_skid2 #(
    .DW(DW)
  ) u_skid (
    .clk  (i_rclk),
    .rst_n(i_rrst_n),
    .push (inflight_reg),
    .din  (i_fifo_data),
    .pop  (pop),
    .dout (o_data),
    .cnt  (cnt)
  );

  assign is_last = (beat_reg == LAST_BEAT);

  // Beat position within the packet and completed-packet count; both only
  // move on an accepted beat, so an empty FIFO never truncates a packet.
  always_ff @(posedge i_rclk) begin
    if (!i_rrst_n) begin
      beat_reg <= '0;
      pkt_reg  <= '0;
    end else if (pop) begin
      if (is_last) begin
        beat_reg <= '0;
        pkt_reg  <= pkt_reg + 1'b1;
      end else begin
        beat_reg <= beat_reg + 1'b1;
      end
    end
  end

  assign o_valid   = (cnt != 2'd0);
  assign o_last    = o_valid & is_last;
  assign o_pkt_cnt = pkt_reg;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO_top read port, scoreboard of
// expected words, and one task per scenario.
module tb_fifo_rd_stream;
  import pkg_graybin::*;

  localparam int PKT_LEN = 4;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  word_t            fifo_data = '0;
  logic             fifo_empty;
  logic             fifo_rden;
  logic             valid;
  logic             ready;
  word_t            data;
  logic             last;
  logic [CNT_W-1:0] pkt_cnt;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .DW     (DW),
    .PKT_LEN(PKT_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .i_rclk      (clk),
    .i_rrst_n    (rst_n),
    .i_fifo_data (fifo_data),
    .i_fifo_empty(fifo_empty),
    .o_fifo_rden (fifo_rden),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_data      (data),
    .o_last      (last),
    .o_pkt_cnt   (pkt_cnt)
  );

  // FIFO_top read port model: one-cycle read latency, flushed by reset
  // unless fifo_hold keeps its contents across reset.
  word_t fmem [0:1023];
  int    wr_ptr = 0;
  int    rd_ptr = 0;
  logic  gap = 1'b0;
  logic  fifo_hold = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr) || gap;

  always @(posedge clk) begin
    if (!rst_n) begin
      if (!fifo_hold) rd_ptr <= wr_ptr;
    end else if (fifo_rden && !fifo_empty) begin
      fifo_data <= fmem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Scoreboard state
  word_t exp_q[$];
  int    exp_beat = 0;
  int    exp_pkt = 0;
  int    outstanding = 0;
  int    pops = 0;
  int    checks = 0;
  int    errors = 0;
  logic  prev_stall = 1'b0;
  word_t prev_data = '0;
  word_t mon_w;

  task automatic load(input word_t w);
    fmem[wr_ptr] = w;
    exp_q.push_back(w);
    wr_ptr++;
  endtask

  // Stream monitor: samples mid-cycle, compares each accepted beat.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      exp_q.delete();
      exp_beat    = 0;
      exp_pkt     = 0;
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (valid !== 1'b1 || data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", valid, data, prev_data);
        end
      end
      if (!valid) begin
        checks++;
        if (last !== 1'b0) begin
          errors++;
          $display("FAIL last_idle: last=%b required 0 while valid=0", last);
        end
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: data=%h required no word", data);
        end else begin
          mon_w = exp_q.pop_front();
          checks++;
          if (data !== mon_w) begin
            errors++;
            $display("FAIL data: got=%h required=%h", data, mon_w);
          end
        end
        checks++;
        if (last !== (exp_beat == PKT_LEN - 1)) begin
          errors++;
          $display("FAIL last: got=%b required=%b (beat %0d)", last, (exp_beat == PKT_LEN - 1), exp_beat);
        end
        checks++;
        if (pkt_cnt !== CNT_W'(exp_pkt)) begin
          errors++;
          $display("FAIL pkt_cnt_beat: got=%0d required=%0d", pkt_cnt, exp_pkt);
        end
        $display("beat data=%h last=%b pkt_cnt=%0d", data, last, pkt_cnt);
        if (exp_beat == PKT_LEN - 1) begin
          exp_beat = 0;
          exp_pkt++;
        end else begin
          exp_beat++;
        end
        pops++;
        outstanding--;
      end
      if (fifo_rden && !fifo_empty) outstanding++;
      checks++;
      if (outstanding > 2 || outstanding < 0) begin
        errors++;
        $display("FAIL occupancy: got=%0d required 0..2", outstanding);
      end
      prev_stall = valid && !ready;
      prev_data  = data;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    gap   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fifo_hold = 1'b1;
    rst_n = 1'b0;
    ready = 1'b1;
    for (int i = 1; i <= 8; i++) load(word_t'(i));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (fifo_rden !== 1'b0 || valid !== 1'b0 || pkt_cnt !== '0 || last !== 1'b0 || data !== '0) begin
        errors++;
        $display("FAIL reset_state: rden=%b valid=%b pkt=%0d last=%b data=%h required all 0",
                 fifo_rden, valid, pkt_cnt, last, data);
      end
    end
    fifo_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    ready = 1'b1;
    @(negedge clk);
    pops = 0;
    for (int i = 1; i <= 8; i++) load(word_t'(i));
    @(negedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: valid=%b required 0", valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (valid !== 1'b1 || data !== word_t'(1)) begin
      errors++;
      $display("FAIL latency_first: valid=%b data=%h required valid=1 data=01", valid, data);
    end
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (valid !== 1'b1) begin
        errors++;
        $display("FAIL throughput: word %0d valid=%b required 1", i, valid);
      end
    end
    repeat (4) @(negedge clk);
    #3;
    checks++;
    if (pkt_cnt !== 8'd2 || pops != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_end: pkt=%0d pops=%0d left=%0d required pkt=2 pops=8 left=0",
               pkt_cnt, pops, exp_q.size());
    end
  endtask

  task automatic test_stall();
    int rd_cnt;
    do_reset();
    ready = 1'b0;
    @(negedge clk);
    pops = 0;
    rd_cnt = 0;
    for (int i = 1; i <= 8; i++) load(word_t'(i));
    for (int c = 0; c < 10; c++) begin
      #1;
      if (fifo_rden && !fifo_empty) rd_cnt++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (rd_cnt != 2) begin
      errors++;
      $display("FAIL stall_reads: got=%0d required=2", rd_cnt);
    end
    checks++;
    if (valid !== 1'b1 || data !== word_t'(1)) begin
      errors++;
      $display("FAIL stall_head: valid=%b data=%h required valid=1 data=01", valid, data);
    end
    ready = 1'b1;
    repeat (12) @(negedge clk);
    #3;
    checks++;
    if (pops != 8 || exp_q.size() != 0 || pkt_cnt !== 8'd2) begin
      errors++;
      $display("FAIL stall_drain: pops=%0d left=%0d pkt=%0d required 8/0/2", pops, exp_q.size(), pkt_cnt);
    end
  endtask

  task automatic test_toggle();
    do_reset();
    @(negedge clk);
    pops = 0;
    for (int i = 0; i < 40; i++) load(word_t'(100 + i));
    for (int c = 0; c < 200; c++) begin
      #1;
      ready = (c % 2 == 0);
      gap   = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    gap   = 1'b0;
    ready = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    checks++;
    if (pops != 40 || exp_q.size() != 0 || pkt_cnt !== 8'd10) begin
      errors++;
      $display("FAIL toggle_end: pops=%0d left=%0d pkt=%0d required 40/0/10", pops, exp_q.size(), pkt_cnt);
    end
  endtask

  task automatic test_gap();
    do_reset();
    ready = 1'b1;
    @(negedge clk);
    pops = 0;
    load(word_t'(1));
    load(word_t'(2));
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (valid !== 1'b1 || data !== word_t'(1)) begin
      errors++;
      $display("FAIL gap_first: valid=%b data=%h required valid=1 data=01", valid, data);
    end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL gap_valid: cycle %0d valid=%b required 0", c, valid);
      end
    end
    checks++;
    if (pkt_cnt !== 8'd0) begin
      errors++;
      $display("FAIL gap_pkt_mid: got=%0d required=0", pkt_cnt);
    end
    for (int i = 3; i <= 6; i++) load(word_t'(i));
    repeat (8) @(negedge clk);
    #3;
    checks++;
    if (pkt_cnt !== 8'd1 || pops != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gap_end: pkt=%0d pops=%0d left=%0d required 1/6/0", pkt_cnt, pops, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b0;
    @(negedge clk);
    pops = 0;
    for (int i = 1; i <= 4; i++) load(word_t'(i));
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (valid !== 1'b1 || data !== word_t'(1)) begin
      errors++;
      $display("FAIL mid_fill: valid=%b data=%h required valid=1 data=01", valid, data);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || pkt_cnt !== '0 || last !== 1'b0) begin
      errors++;
      $display("FAIL mid_cleared: valid=%b pkt=%0d last=%b required 0/0/0", valid, pkt_cnt, last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_discard: valid=%b required 0", valid);
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) load(word_t'(8'h50 + i));
    repeat (8) @(negedge clk);
    #3;
    checks++;
    if (pops != 4 || pkt_cnt !== 8'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_after: pops=%0d pkt=%0d left=%0d required 4/1/0", pops, pkt_cnt, exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_toggle();
    test_gap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
